// File: rtl/vending_ctrl_param.sv
// ---------------------------------------------------------------------------
// vending_ctrl_param
//
// Coin-accepting vending controller. Accepts 5c/10c/25c coins, accumulates
// credit against PRICE, issues a one-cycle vend pulse, then pays back any
// overpayment as a train of one-cycle 5c change pulses. Supports cancel/refund,
// stock tracking with sold-out coin rejection, and restock.
//
// State table
//   state  | meaning
//   ACCUM  | idle / collecting coins, credit < PRICE
//   VEND   | one-cycle dispense, stock decrements on exit
//   CHANGE | returning credit one nickel per cycle
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   coin[1:0]      00 none, 01 5c, 10 10c, 11 25c (one coin per cycle)
//   cancel         refund request, level sampled each cycle
//   restock        reload stock to STOCK_INIT (any state)
//   vend           high for the single cycle spent in VEND
//   change_nickel  high for every cycle spent in CHANGE (one 5c each)
//   coin_reject    registered pulse, the cycle after a refused coin
//   busy           state != ACCUM
//   sold_out       stock == 0
//   credit[CW-1:0] current credit in cents (registered)
//   stock[SW-1:0]  remaining items (registered)
// ---------------------------------------------------------------------------
module vending_ctrl_param #(
  parameter int         PRICE      = 15,
  parameter int         CW         = 6,
  parameter int         STOCK_INIT = 4,
  parameter int         SW         = 4,
  parameter logic [2:0] COIN_EN    = 3'b111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    coin,
  input  logic          cancel,
  input  logic          restock,
  output logic          vend,
  output logic          change_nickel,
  output logic          coin_reject,
  output logic          busy,
  output logic          sold_out,
  output logic [CW-1:0] credit,
  output logic [SW-1:0] stock
);

  typedef enum logic [1:0] {
    ACCUM  = 2'b00,
    VEND   = 2'b01,
    CHANGE = 2'b10
  } state_t;

  localparam logic [CW-1:0] PRICE_C      = CW'(PRICE);
  localparam logic [CW-1:0] NICKEL       = CW'(5);
  localparam logic [SW-1:0] STOCK_INIT_C = SW'(STOCK_INIT);

  state_t        state, state_next;
  logic [CW-1:0] credit_next;
  logic [SW-1:0] stock_next;
  logic          reject_next;

  logic [CW-1:0] coin_value;
  logic          coin_present;
  logic          coin_enabled;
  logic [CW-1:0] sum;

  // Coin decode. The PRICE+20 < 2**CW constraint guarantees sum fits in CW
  // bits, since credit in ACCUM never exceeds PRICE-5.
  always_comb begin
    coin_value   = '0;
    coin_enabled = 1'b0;
    case (coin)
      2'b01: begin
        coin_value   = CW'(5);
        coin_enabled = COIN_EN[0];
      end
      2'b10: begin
        coin_value   = CW'(10);
        coin_enabled = COIN_EN[1];
      end
      2'b11: begin
        coin_value   = CW'(25);
        coin_enabled = COIN_EN[2];
      end
      default: begin
        coin_value   = '0;
        coin_enabled = 1'b0;
      end
    endcase
    coin_present = (coin != 2'b00);
    sum          = credit + coin_value;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACCUM;
      credit      <= '0;
      stock       <= STOCK_INIT_C;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      stock       <= stock_next;
      coin_reject <= reject_next;
    end
  end

  always_comb begin
    state_next  = state;
    credit_next = credit;
    stock_next  = stock;
    reject_next = 1'b0;

    case (state)
      ACCUM: begin
        if (cancel) begin
          // Cancel wins over any coin offered in the same cycle.
          reject_next = coin_present;
          if (credit != '0) begin
            state_next = CHANGE;
          end
        end else if (coin_present) begin
          if (coin_enabled && (stock != '0)) begin
            if (sum >= PRICE_C) begin
              credit_next = sum - PRICE_C;
              state_next  = VEND;
            end else begin
              credit_next = sum;
            end
          end else begin
            reject_next = 1'b1;
          end
        end
      end

      VEND: begin
        reject_next = coin_present;
        if (stock != '0) begin
          stock_next = stock - SW'(1);
        end
        state_next = (credit != '0) ? CHANGE : ACCUM;
      end

      CHANGE: begin
        reject_next = coin_present;
        // Credit is always a multiple of 5 here; the <= guard also protects
        // against a stray non-multiple ever wrapping around.
        if (credit > NICKEL) begin
          credit_next = credit - NICKEL;
        end else begin
          credit_next = '0;
          state_next  = ACCUM;
        end
      end

      default: begin
        // Unused encoding: recover to a clean idle state.
        reject_next = coin_present;
        credit_next = '0;
        state_next  = ACCUM;
      end
    endcase

    // Restock overrides the VEND decrement in the same cycle.
    if (restock) begin
      stock_next = STOCK_INIT_C;
    end
  end

  assign vend          = (state == VEND);
  assign change_nickel = (state == CHANGE);
  assign busy          = (state != ACCUM);
  assign sold_out      = (stock == '0);

endmodule

// File: tb/tb_vending_ctrl_param.sv
module tb_vending_ctrl_param;

  logic       clk;
  logic       reset;
  logic [1:0] coin;
  logic       cancel;
  logic       restock;
  logic       vend, change_nickel, coin_reject, busy, sold_out;
  logic [5:0] credit;
  logic [3:0] stock;

  logic [1:0] coin_b;
  logic       cancel_b;
  logic       restock_b;
  logic       vend_b, change_nickel_b, coin_reject_b, busy_b, sold_out_b;
  logic [5:0] credit_b;
  logic [3:0] stock_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       v;
    logic       c;
    logic       r;
    logic [5:0] cr;
    logic [3:0] st;
  } ev_t;

  ev_t exp_q[$];

  vending_ctrl_param dut (
    .clk(clk), .reset(reset), .coin(coin), .cancel(cancel), .restock(restock),
    .vend(vend), .change_nickel(change_nickel), .coin_reject(coin_reject),
    .busy(busy), .sold_out(sold_out), .credit(credit), .stock(stock)
  );

  vending_ctrl_param #(.COIN_EN(3'b011)) dut_b (
    .clk(clk), .reset(reset), .coin(coin_b), .cancel(cancel_b), .restock(restock_b),
    .vend(vend_b), .change_nickel(change_nickel_b), .coin_reject(coin_reject_b),
    .busy(busy_b), .sold_out(sold_out_b), .credit(credit_b), .stock(stock_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input bit v, input bit c, input bit r, input int cr, input int st);
    ev_t e;
    e.v  = v;
    e.c  = c;
    e.r  = r;
    e.cr = 6'(cr);
    e.st = 4'(st);
    exp_q.push_back(e);
  endtask

  // One clock with the given inputs applied, inputs cleared #1 after the edge.
  task automatic cycle(input logic [1:0] c, input logic can, input logic rs);
    coin    = c;
    cancel  = can;
    restock = rs;
    @(posedge clk);
    #1;
    coin    = 2'b00;
    cancel  = 1'b0;
    restock = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0);
  endtask

  task automatic cycle_b(input logic [1:0] c);
    coin_b = c;
    @(posedge clk);
    #1;
    coin_b = 2'b00;
  endtask

  // Monitor: every cycle with a pulse output is matched against the queue.
  always @(negedge clk) begin
    if (!reset && (vend || change_nickel || coin_reject)) begin
      ev_t got;
      ev_t want;
      got.v  = vend;
      got.c  = change_nickel;
      got.r  = coin_reject;
      got.cr = credit;
      got.st = stock;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event unexpected: vend/chg/rej=%b%b%b credit=%0d stock=%0d expected no event",
                 got.v, got.c, got.r, got.cr, got.st);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL event: got vend/chg/rej=%b%b%b credit=%0d stock=%0d expected vend/chg/rej=%b%b%b credit=%0d stock=%0d",
                   got.v, got.c, got.r, got.cr, got.st, want.v, want.c, want.r, want.cr, want.st);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; coin = 2'b00; cancel = 1'b0; restock = 1'b0;
    coin_b = 2'b00; cancel_b = 1'b0; restock_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset credit", credit, 0);
    check("reset stock", stock, 4);
    check("reset busy", busy, 0);
    check("reset sold_out", sold_out, 0);
    check("reset pulses", {vend, change_nickel, coin_reject}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: 5 + 10 -> exact price, single vend
    cycle(2'b01, 0, 0);
    check("t1 credit after 5", credit, 5);
    expect_ev(1, 0, 0, 0, 4);
    cycle(2'b10, 0, 0);
    check("t1 busy in vend", busy, 1);
    idle(1);
    check("t1 credit", credit, 0);
    check("t1 stock", stock, 3);

    // 2: 10 + 25 -> credit 20, four change pulses
    cycle(2'b10, 0, 0);
    expect_ev(1, 0, 0, 20, 3);
    expect_ev(0, 1, 0, 20, 2);
    expect_ev(0, 1, 0, 15, 2);
    expect_ev(0, 1, 0, 10, 2);
    expect_ev(0, 1, 0, 5, 2);
    cycle(2'b11, 0, 0);
    idle(5);
    check("t2 credit", credit, 0);
    check("t2 busy", busy, 0);
    check("t2 stock", stock, 2);

    // 3a: coin 5 then cancel -> one nickel back
    cycle(2'b01, 0, 0);
    expect_ev(0, 1, 0, 5, 2);
    cycle(2'b00, 1, 0);
    idle(1);
    check("t3a credit", credit, 0);
    check("t3a stock", stock, 2);
    // 3b: coin + cancel with credit 5 -> refund and reject together
    cycle(2'b01, 0, 0);
    expect_ev(0, 1, 1, 5, 2);
    cycle(2'b10, 1, 0);
    idle(1);
    check("t3b credit", credit, 0);
    // 3c: coin + cancel with no credit -> reject only
    expect_ev(0, 0, 1, 0, 2);
    cycle(2'b10, 1, 0);
    check("t3c reject", coin_reject, 1);
    check("t3c busy", busy, 0);
    idle(1);
    check("t3c reject cleared", coin_reject, 0);

    // 4: drain stock, sold-out rejection, restock
    expect_ev(1, 0, 0, 10, 2);
    expect_ev(0, 1, 0, 10, 1);
    expect_ev(0, 1, 0, 5, 1);
    cycle(2'b11, 0, 0);
    idle(3);
    cycle(2'b01, 0, 0);
    cycle(2'b01, 0, 0);
    expect_ev(1, 0, 0, 0, 1);
    cycle(2'b01, 0, 0);
    idle(1);
    check("t4 stock", stock, 0);
    check("t4 sold_out", sold_out, 1);
    expect_ev(0, 0, 1, 0, 0);
    cycle(2'b10, 0, 0);
    check("t4 sold-out credit", credit, 0);
    idle(1);
    cycle(2'b00, 0, 1);
    check("t4 restock stock", stock, 4);
    check("t4 restock sold_out", sold_out, 0);

    // restock in the VEND cycle beats the decrement
    cycle(2'b10, 0, 0);
    expect_ev(1, 0, 0, 0, 4);
    cycle(2'b01, 0, 0);
    cycle(2'b00, 0, 1);
    check("restock vs vend", stock, 4);

    // 5: coins during VEND and CHANGE are refused, change train intact
    cycle(2'b10, 0, 0);
    expect_ev(1, 0, 0, 20, 4);
    expect_ev(0, 1, 1, 20, 3);
    expect_ev(0, 1, 1, 15, 3);
    expect_ev(0, 1, 0, 10, 3);
    expect_ev(0, 1, 0, 5, 3);
    cycle(2'b11, 0, 0);
    cycle(2'b01, 0, 0);
    cycle(2'b10, 0, 0);
    idle(3);
    check("t5 credit", credit, 0);
    check("t5 busy", busy, 0);
    check("t5 stock", stock, 3);

    // 5b: 25c disabled on the second instance
    cycle_b(2'b11);
    check("b 25c reject", coin_reject_b, 1);
    check("b 25c credit", credit_b, 0);
    cycle_b(2'b10);
    check("b 10c credit", credit_b, 10);
    check("b 10c no reject", coin_reject_b, 0);
    cycle_b(2'b01);
    check("b vend", vend_b, 1);
    check("b credit at vend", credit_b, 0);
    cycle_b(2'b00);
    check("b stock", stock_b, 3);

    // 6: asynchronous reset in the middle of a change train
    cycle(2'b10, 0, 0);
    expect_ev(1, 0, 0, 20, 3);
    expect_ev(0, 1, 0, 20, 2);
    expect_ev(0, 1, 0, 15, 2);
    cycle(2'b11, 0, 0);
    idle(2);
    check("t6 credit before reset", credit, 15);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6 credit", credit, 0);
    check("t6 stock", stock, 4);
    check("t6 busy", busy, 0);
    check("t6 change_nickel", change_nickel, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    check("t6 idle credit", credit, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL events pending: got %0d left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
